if_pc_fetch: RTL and testbench
==============================

// Module: if_pc_fetch
// PURPOSE
//  Parametrised PC generator and instruction-fetch front end for the IF stage.
//  Issues fetch requests on an addr_ok/data_ok instruction-SRAM bus and holds a
//  returned instruction until ID accepts it. Redirects are prioritised:
//  exception flush first, then branch, then sequential. Fetches that are in
//  flight when a redirect arrives are cancelled and their data discarded.
// PARAMETERS
//  PC_W       32            PC / address width
//  RESET_VEC  32'h1c000000  first fetch address after reset
//  STRIDE     4             sequential increment in bytes (power of 2)
// PORTS
//  clk            in   1     clock; all state changes on posedge clk
//  rst            in   1     reset: one clock, synchronous, active-high
//  inst_req       out  1     fetch request valid
//  inst_addr      out  PC_W  fetch address (= fetch_pc)
//  inst_addr_ok   in   1     request accepted this cycle
//  inst_data_ok   in   1     read data valid this cycle
//  inst_rdata     in   32    read data
//  br_taken       in   1     branch redirect (one-cycle pulse)
//  br_target      in   PC_W  branch target
//  exc_flush      in   1     exception/ertn redirect (one-cycle pulse)
//  exc_target     in   PC_W  exception target
//  id_allowin     in   1     ID accepts the instruction this cycle
//  if_valid       out  1     if_pc/if_inst valid to ID
//  if_pc          out  PC_W  PC of the held instruction
//  if_inst        out  32    held instruction
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE; fetch_pc=RESET_VEC; cancel=0;
//   inst_req=0; if_valid=0; if_pc=0; if_inst=0.
//  States: IDLE, REQ, WAIT, HOLD. inst_req=1 only in REQ; if_valid=1 only in HOLD.
//  IDLE: next cycle -> REQ.
//  REQ: inst_addr=fetch_pc. When addr_ok=1: req_pc<=fetch_pc,
//   fetch_pc<=fetch_pc+STRIDE (mod 2^PC_W), state -> WAIT.
//  WAIT: on data_ok=1: if cancel=1, drop the data, cancel<=0, -> REQ;
//   otherwise if_pc<=req_pc, if_inst<=inst_rdata, -> HOLD.
//  HOLD: output stays stable while id_allowin=0. When id_allowin=1 -> REQ;
//   if_valid is 0 from the next cycle.
//  Redirect: target = exc_flush ? exc_target : br_target; its low log2(STRIDE)
//   bits are forced to 0. Applies in any state except under rst:
//   - fetch_pc<=target; this overrides the +STRIDE update in the same cycle.
//   - REQ with addr_ok=0: the request stays up; inst_addr=target next cycle.
//   - REQ with addr_ok=1: accepted, then cancelled; -> WAIT with cancel=1.
//   - WAIT with data_ok=0: cancel<=1.
//   - WAIT with data_ok=1: data dropped; -> REQ; cancel<=0.
//   - HOLD: the instruction is discarded; -> REQ; no handshake with ID.
//   - Redirect while cancel=1: only fetch_pc updates.
//   - exc_flush and br_taken together: exc_target wins.
//  Latency: redirect at cycle N -> inst_req with addr=target at N+1, unless a
//   cancelled fetch is still outstanding.
//  At most one outstanding request. Sequential throughput: 1 instruction per
//   3 cycles when addr_ok and data_ok each take 1 cycle.
//  rst mid-transaction: state goes to IDLE and cancel is cleared. The bus slave
//   is reset by the same rst, so no stale data_ok arrives afterwards.
//  Wrap: 32'hfffffffc + 4 -> 32'h0, with no flag.
// TESTING
//  1 Reset, then addr_ok and data_ok each 1 cycle later: addresses
//    1c000000, 1c000004, 1c000008 in order; if_pc matches each; if_inst=rdata.
//  2 Hold id_allowin=0 for 5 cycles in HOLD: if_valid, if_pc and if_inst are
//    stable; inst_req=0 throughout.
//  3 br_taken, target 1c000100, during WAIT: the next data_ok is dropped
//    (if_valid stays 0); the next request has addr 1c000100.
//  4 exc_flush (target 1c008000) and br_taken (target 1c000200) in the same
//    cycle: the next inst_addr is 1c008000.
//  5 br_target=1c000103: inst_addr is 1c000100.
//  6 rst during WAIT, then 2 cycles later data_ok=0: state is IDLE, then REQ
//    at RESET_VEC; also fetch_pc=fffffffc sequential -> next address 00000000.

Source files
------------

// File: rtl/if_pc_fetch_if.sv
// Instruction-SRAM bus (addr_ok/data_ok) between IF fetch and memory.
// master: inst_req/inst_addr out; slave: addr_ok/data_ok/rdata out.
interface if_pc_fetch_if #(
  parameter int PC_W = 32
);
  logic            inst_req;
  logic [PC_W-1:0] inst_addr;
  logic            inst_addr_ok;
  logic            inst_data_ok;
  logic [31:0]     inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/if_pc_fetch.sv
// PC generator / instruction fetch front end for the IF stage.
// Ports: clk, rst, bus (SRAM master), redirects, id_allowin, if_* to ID.
module if_pc_fetch #(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = 32'h1c000000,
  parameter int              STRIDE    = 4
) (
  input  logic             clk,
  input  logic             rst,
  if_pc_fetch_if.master    bus,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_target,
  input  logic             exc_flush,
  input  logic [PC_W-1:0]  exc_target,
  input  logic             id_allowin,
  output logic             if_valid,
  output logic [PC_W-1:0]  if_pc,
  output logic [31:0]      if_inst
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  localparam logic [PC_W-1:0] LOW_MASK = PC_W'(STRIDE - 1);
  localparam logic [PC_W-1:0] STEP     = PC_W'(STRIDE);

  state_t          state_q;
  logic [PC_W-1:0] fetch_pc_q;
  logic [PC_W-1:0] req_pc_q;
  logic            cancel_q;
  logic [PC_W-1:0] if_pc_q;
  logic [31:0]     if_inst_q;

  logic            redir;
  logic [PC_W-1:0] redir_pc;

  // Exception beats branch; target is forced onto a STRIDE boundary.
  assign redir    = exc_flush | br_taken;
  assign redir_pc = (exc_flush ? exc_target : br_target) & ~LOW_MASK;

  assign bus.inst_req  = (state_q == REQ);
  assign bus.inst_addr = fetch_pc_q;
  assign if_valid      = (state_q == HOLD);
  assign if_pc         = if_pc_q;
  assign if_inst       = if_inst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_VEC;
      req_pc_q   <= '0;
      cancel_q   <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (bus.inst_addr_ok) begin
            req_pc_q   <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_q + STEP;
            state_q    <= WAIT;
            // Accepted fetch is already stale if a redirect lands now.
            if (redir) cancel_q <= 1'b1;
          end
        end
        WAIT: begin
          if (bus.inst_data_ok) begin
            if (cancel_q || redir) begin
              cancel_q <= 1'b0;
              state_q  <= REQ;
            end else begin
              if_pc_q   <= req_pc_q;
              if_inst_q <= bus.inst_rdata;
              state_q   <= HOLD;
            end
          end else if (redir) begin
            cancel_q <= 1'b1;
          end
        end
        HOLD: begin
          if (redir || id_allowin) state_q <= REQ;
        end
        default: state_q <= IDLE;
      endcase
      // Redirect wins over the sequential increment above.
      if (redir) fetch_pc_q <= redir_pc;
    end
  end

endmodule

// File: tb/tb_if_pc_fetch.sv
// Scenario bench for if_pc_fetch with a pc/inst scoreboard queue.
// Bus slave and redirects are driven cycle by cycle from tasks.
module tb_if_pc_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_flush;
  logic [31:0] exc_target;
  logic        id_allowin;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  if_pc_fetch_if #(.PC_W(32)) bus ();

  if_pc_fetch #(
    .PC_W(32),
    .RESET_VEC(32'h1c000000),
    .STRIDE(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .br_taken(br_taken),
    .br_target(br_target),
    .exc_flush(exc_flush),
    .exc_target(exc_target),
    .id_allowin(id_allowin),
    .if_valid(if_valid),
    .if_pc(if_pc),
    .if_inst(if_inst)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects REQ at the sample point; completes one uncancelled fetch.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    checks++;
    if (bus.inst_req !== 1'b1 || bus.inst_addr !== addr) begin
      errors++;
      $display("FAIL fetch_req: req=%b addr=%h want req=1 addr=%h",
               bus.inst_req, bus.inst_addr, addr);
    end
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = data;
    tick();
    bus.inst_data_ok = 1'b0;
    e.pc   = addr;
    e.inst = data;
    sb.push_back(e);
  endtask

  // Pops the scoreboard when ID takes the held instruction.
  task automatic consume();
    exp_t e;
    checks++;
    if (if_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL consume_valid: if_valid=%b sb=%0d want 1", if_valid, sb.size());
      return;
    end
    e = sb.pop_front();
    checks++;
    if (if_pc !== e.pc || if_inst !== e.inst) begin
      errors++;
      $display("FAIL consume_data: pc=%h inst=%h want pc=%h inst=%h",
               if_pc, if_inst, e.pc, e.inst);
    end
    id_allowin = 1'b1;
    tick();
    id_allowin = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || bus.inst_req !== 1'b1) begin
      errors++;
      $display("FAIL consume_next: if_valid=%b req=%b want 0/1", if_valid, bus.inst_req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (bus.inst_req !== 1'b0 || if_valid !== 1'b0 ||
        if_pc !== 32'h0 || if_inst !== 32'h0) begin
      errors++;
      $display("FAIL reset: req=%b v=%b pc=%h inst=%h want 0/0/0/0",
               bus.inst_req, if_valid, if_pc, if_inst);
    end
    tick();
  endtask

  task automatic test_seq();
    logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      a = 32'h1c000000 + 32'(4 * i);
      do_fetch(a, 32'hA0000000 | 32'(i));
      consume();
    end
  endtask

  task automatic test_hold();
    do_fetch(32'h1c00000c, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h1c00000c ||
          if_inst !== 32'h12345678 || bus.inst_req !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: v=%b pc=%h inst=%h req=%b want 1/1c00000c/12345678/0",
                 i, if_valid, if_pc, if_inst, bus.inst_req);
      end
      tick();
    end
    consume();
  endtask

  task automatic test_branch_wait();
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    br_taken  = 1'b1;
    br_target = 32'h1c000100;
    tick();
    br_taken = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hdeadbeef;
    tick();
    bus.inst_data_ok = 1'b0;
    checks++;
    if (if_valid !== 1'b0) begin
      errors++;
      $display("FAIL br_drop: if_valid=%b want 0", if_valid);
    end
    do_fetch(32'h1c000100, 32'h0badf00d);
    consume();
  endtask

  task automatic test_exc_priority();
    exc_flush  = 1'b1;
    exc_target = 32'h1c008000;
    br_taken   = 1'b1;
    br_target  = 32'h1c000200;
    tick();
    exc_flush = 1'b0;
    br_taken  = 1'b0;
    do_fetch(32'h1c008000, 32'h11112222);
    consume();
  endtask

  task automatic test_align();
    br_taken  = 1'b1;
    br_target = 32'h1c000103;
    tick();
    br_taken = 1'b0;
    do_fetch(32'h1c000100, 32'h33334444);
    consume();
  endtask

  task automatic test_hold_redirect();
    do_fetch(32'h1c000104, 32'h55556666);
    void'(sb.pop_front());
    br_taken  = 1'b1;
    br_target = 32'h1c000400;
    tick();
    br_taken = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h1c000400) begin
      errors++;
      $display("FAIL hold_redir: v=%b req=%b addr=%h want 0/1/1c000400",
               if_valid, bus.inst_req, bus.inst_addr);
    end
  endtask

  task automatic test_rst_wait();
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.inst_req !== 1'b0 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle: req=%b v=%b want 0/0", bus.inst_req, if_valid);
    end
    tick();
    do_fetch(32'h1c000000, 32'h77778888);
    consume();
    br_taken  = 1'b1;
    br_target = 32'hfffffffc;
    tick();
    br_taken = 1'b0;
    do_fetch(32'hfffffffc, 32'h9999aaaa);
    consume();
    checks++;
    if (bus.inst_addr !== 32'h00000000) begin
      errors++;
      $display("FAIL wrap: addr=%h want 00000000", bus.inst_addr);
    end
  endtask

  initial begin
    rst              = 1'b1;
    br_taken         = 1'b0;
    br_target        = '0;
    exc_flush        = 1'b0;
    exc_target       = '0;
    id_allowin       = 1'b0;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = '0;
    test_reset();
    test_seq();
    test_hold();
    test_branch_wait();
    test_exc_priority();
    test_align();
    test_hold_redirect();
    test_rst_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
